pipe_hazard_ctrl: RTL

//  Centralised hazard/bypass controller for the 5-stage pipeline (F/D/X/M/W).

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_hazard_ctrl_md_seq.sv | 62 ++++++
 rtl/pipe_hazard_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard/bypass controller.
package pipe_pkg;

  localparam int unsigned REG_AW_DEF = 5;

  // X-stage operand source selects
  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_M   = 2'd1;
  localparam logic [1:0] FWD_W   = 2'd2;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_md_seq.sv
// md_seq: mult/div sequencer; start pulse, MD_LATENCY-1 cycles later a one-cycle done.
module md_seq
  import pipe_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic start_req,
  output logic md_start,
  output logic md_done,
  output logic md_busy,
  output logic md_stall
);

  localparam logic [7:0] CNT_LOAD = 8'(MD_LATENCY - 2);

  md_state_e  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output gets a default before the case, so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_start = 1'b0;
    md_done  = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        if (start_req) begin
          md_start = 1'b1;
          cnt_d    = CNT_LOAD;
          // Minimum latency of 2 has no BUSY cycles at all.
          state_d  = (CNT_LOAD == 8'd0) ? MD_DONE : MD_BUSY;
        end
      end
      MD_BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) state_d = MD_DONE;
      end
      MD_DONE: begin
        md_done = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign md_busy  = (state_q != MD_IDLE);
  assign md_stall = (state_q == MD_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/bypass controller: stalls, flushes, X-stage bypass selects, mult/div sequencing.
// Optional HAZARD_PERF_EN adds saturating stall/flush event counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW     = REG_AW_DEF,
  parameter int unsigned MD_LATENCY = 32,
  parameter int unsigned PERF_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs_a,
  input  logic [REG_AW-1:0] d_rs_b,
  input  logic              d_use_a,
  input  logic              d_use_b,
  input  logic              x_valid,
  input  logic              x_is_load,
  input  logic              x_is_md,
  input  logic              x_wen,
  input  logic [REG_AW-1:0] x_rd,
  input  logic [REG_AW-1:0] x_rs_a,
  input  logic [REG_AW-1:0] x_rs_b,
  input  logic              branch_taken,
  input  logic              m_wen,
  input  logic [REG_AW-1:0] m_rd,
  input  logic              w_wen,
  input  logic [REG_AW-1:0] w_rd,
  output logic              stall_fd,
  output logic              stall_dx,
  output logic              bubble_xm,
  output logic              flush_fd,
  output logic              flush_dx,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic              md_start,
  output logic              md_done,
  output logic              md_busy,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
);

  logic md_stall;
  logic load_use;
  logic branch_flush;

  // M is younger than W, so it holds the newer value on a double match.
  function automatic logic [1:0] bypass_sel(
    input logic [REG_AW-1:0] src,
    input logic              mw,
    input logic [REG_AW-1:0] mr,
    input logic              ww,
    input logic [REG_AW-1:0] wr
  );
    if (src == '0)            return FWD_REG;
    if (mw && (mr == src))    return FWD_M;
    if (ww && (wr == src))    return FWD_W;
    return FWD_REG;
  endfunction

  assign fwd_sel_a = bypass_sel(x_rs_a, m_wen, m_rd, w_wen, w_rd);
  assign fwd_sel_b = bypass_sel(x_rs_b, m_wen, m_rd, w_wen, w_rd);

  assign load_use = x_valid && x_is_load && x_wen && (x_rd != '0) && d_valid &&
                    ((d_use_a && (d_rs_a == x_rd)) || (d_use_b && (d_rs_b == x_rd)));

  md_seq #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_seq (
    .clock     (clock),
    .reset     (reset),
    .start_req (x_valid && x_is_md && !branch_taken),
    .md_start  (md_start),
    .md_done   (md_done),
    .md_busy   (md_busy),
    .md_stall  (md_stall)
  );

  // A taken branch cannot legitimately coexist with BUSY; it is ignored there.
  assign branch_flush = branch_taken && !md_stall;

  always_comb begin
    stall_fd  = 1'b0;
    stall_dx  = 1'b0;
    bubble_xm = 1'b0;
    flush_fd  = 1'b0;
    flush_dx  = 1'b0;
    if (branch_flush) begin
      flush_fd = 1'b1;
      flush_dx = 1'b1;
    end else if (md_stall) begin
      stall_fd  = 1'b1;
      stall_dx  = 1'b1;
      bubble_xm = 1'b1;
    end else if (load_use) begin
      stall_fd = 1'b1;
      flush_dx = 1'b1;
    end
  end

  a_no_branch_in_md_busy: assert property (
    @(posedge clock) disable iff (!reset) !(md_stall && branch_taken)
  );

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_fd && (stall_cnt != '1))     stall_cnt <= stall_cnt + PERF_W'(1);
      if (branch_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + PERF_W'(1);
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
